// File: rtl/gate_chk_pkg.sv
// Shared constants for the gate response checker: FSM encoding and common
// two-input gate truth tables, indexed by {a,b}.
package gate_chk_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  function automatic logic [3:0] cov_bit(input logic a, input logic b);
    return 4'b0001 << {a, b};
  endfunction

endpackage

// File: rtl/gate_resp_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (inc && (q_q != '1))
      q_d = q_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/gate_resp_checker.sv
// Monitor for a two-input gate: checks sampled (a,b,y) against TRUTH_TABLE,
// tracks coverage of {a,b}. Optional timeout port under GATE_CHK_TIMEOUT_EN.
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE    = TT_XNOR,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             smp_valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [3:0]       cov,
`ifdef GATE_CHK_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic [1:0] state_q, state_d;
  logic [3:0] cov_q, cov_d;
  logic       mismatch_q, mismatch_d;
  logic       sample_en, sample_bad;
  logic [1:0] idx;

  assign idx        = {a, b};
  // start outranks a coincident sample: the clear wins and the sample is dropped
  assign sample_en  = (state_q == ST_CHECK) && smp_valid && !start;
  assign sample_bad = sample_en && (y != TRUTH_TABLE[idx]);

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk(clk), .rst(rst), .clr(start), .inc(sample_en),  .q(vec_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(start), .inc(sample_bad), .q(err_cnt)
  );

`ifdef GATE_CHK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cyc_cnt;
  logic          timeout_q, timeout_d;
  logic          tmo_hit;

  sat_counter #(.W(TW)) u_cyc_cnt (
    .clk(clk), .rst(rst), .clr(start),
    .inc((state_q == ST_CHECK) && !start), .q(cyc_cnt)
  );

  assign tmo_hit = (state_q == ST_CHECK) && !start &&
                   (cyc_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d    = state_q;
    cov_d      = cov_q;
    mismatch_d = 1'b0;
`ifdef GATE_CHK_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif
    if (start) begin
      state_d = ST_CHECK;
      cov_d   = '0;
`ifdef GATE_CHK_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
    end else if (state_q == ST_CHECK) begin
      if (sample_en) begin
        cov_d      = cov_q | cov_bit(a, b);
        mismatch_d = sample_bad;
      end
      // full coverage takes precedence over a simultaneous timeout
      if (cov_d == 4'b1111)
        state_d = ST_DONE;
`ifdef GATE_CHK_TIMEOUT_EN
      else if (tmo_hit) begin
        state_d   = ST_DONE;
        timeout_d = 1'b1;
      end
`endif
    end else if (state_q != ST_DONE) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cov_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cov_q      <= cov_d;
      mismatch_q <= mismatch_d;
    end
  end

`ifdef GATE_CHK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_d;
  end

  assign timeout = timeout_q;
  assign pass    = (state_q == ST_DONE) && (err_cnt == '0) && !timeout_q;
`else
  assign pass    = (state_q == ST_DONE) && (err_cnt == '0);
`endif

  assign busy     = (state_q == ST_CHECK);
  assign done     = (state_q == ST_DONE);
  assign mismatch = mismatch_q;
  assign cov      = cov_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed bench for gate_resp_checker: XNOR (CNT_W=8), AND, and a CNT_W=2
// saturation instance share stimulus; timeout steps need GATE_CHK_TIMEOUT_EN.
module tb_gate_resp_checker;
  import gate_chk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, smp_valid, a, b, y, y_and;

  logic       busy, done, pass, mismatch;
  logic [3:0] cov;
  logic [7:0] vec_cnt, err_cnt;

  logic       busy_and, done_and, pass_and, mismatch_and;
  logic [3:0] cov_and;
  logic [7:0] vec_and, err_and;

  logic       busy_sat, done_sat, pass_sat, mismatch_sat;
  logic [3:0] cov_sat;
  logic [1:0] vec_sat, err_sat;

`ifdef GATE_CHK_TIMEOUT_EN
  logic timeout, timeout_and, timeout_sat;
`endif

  int n_vec = 0;
  int n_err = 0;

  gate_resp_checker #(.TRUTH_TABLE(TT_XNOR), .CNT_W(8), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch), .cov(cov),
`ifdef GATE_CHK_TIMEOUT_EN
    .timeout(timeout),
`endif
    .vec_cnt(vec_cnt), .err_cnt(err_cnt)
  );

  gate_resp_checker #(.TRUTH_TABLE(TT_AND), .CNT_W(8), .TIMEOUT_CYCLES(10)) dut_and (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .y(y_and),
    .busy(busy_and), .done(done_and), .pass(pass_and), .mismatch(mismatch_and),
    .cov(cov_and),
`ifdef GATE_CHK_TIMEOUT_EN
    .timeout(timeout_and),
`endif
    .vec_cnt(vec_and), .err_cnt(err_and)
  );

  gate_resp_checker #(.TRUTH_TABLE(TT_XNOR), .CNT_W(2), .TIMEOUT_CYCLES(10)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .y(y),
    .busy(busy_sat), .done(done_sat), .pass(pass_sat), .mismatch(mismatch_sat),
    .cov(cov_sat),
`ifdef GATE_CHK_TIMEOUT_EN
    .timeout(timeout_sat),
`endif
    .vec_cnt(vec_sat), .err_cnt(err_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic ia, input logic ib, input logic iy, input logic iya);
    a = ia; b = ib; y = iy; y_and = iya;
    smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    rst = 1'b1; start = 1'b0; smp_valid = 1'b0;
    a = 1'b0; b = 1'b0; y = 1'b0; y_and = 1'b0;

    // 1: reset and IDLE ignores samples
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_cov", cov, 0);
    chk("rst_vec", vec_cnt, 0);
    chk("rst_err", err_cnt, 0);
    smp(1'b1, 1'b1, 1'b0, 1'b0);
    smp(1'b0, 1'b1, 1'b1, 1'b1);
    chk("idle_vec", vec_cnt, 0);
    chk("idle_cov", cov, 0);
    chk("idle_busy", busy, 0);

    // 2: correct XNOR / AND sweep
    do_start();
    chk("t2_busy", busy, 1);
    smp(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_mm0", mismatch, 0);
    chk("t2_vec1", vec_cnt, 1);
    chk("t2_cov1", cov, 4'b0001);
    smp(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_mm1", mismatch, 0);
    smp(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_mm2", mismatch, 0);
    chk("t2_done3", done, 0);
    smp(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t2_mm3", mismatch, 0);
    chk("t2_done", done, 1);
    chk("t2_busy_off", busy, 0);
    chk("t2_pass", pass, 1);
    chk("t2_vec", vec_cnt, 4);
    chk("t2_err", err_cnt, 0);
    chk("t2_cov", cov, 4'b1111);
    chk("t2_and_pass", pass_and, 1);
    chk("t2_sat_vec", vec_sat, 3);
    chk("t2_sat_pass", pass_sat, 1);
    smp(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_done_ignores_vec", vec_cnt, 4);
    chk("t2_done_ignores_mm", mismatch, 0);

    // 3: faulty output on 11
    do_start();
    chk("t3_clr_vec", vec_cnt, 0);
    chk("t3_clr_cov", cov, 0);
    smp(1'b0, 1'b0, 1'b1, 1'b0);
    smp(1'b0, 1'b1, 1'b0, 1'b0);
    smp(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_mm_before", mismatch, 0);
    smp(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t3_mm", mismatch, 1);
    chk("t3_err", err_cnt, 1);
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_and_pass", pass_and, 1);
    tick();
    chk("t3_mm_after", mismatch, 0);
    chk("t3_err_hold", err_cnt, 1);

    // 4: repeats and gaps
    do_start();
    smp(1'b0, 1'b0, 1'b1, 1'b0); tick();
    smp(1'b0, 1'b0, 1'b1, 1'b0); tick();
    smp(1'b0, 1'b1, 1'b0, 1'b0); tick();
    smp(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_vec4", vec_cnt, 4);
    chk("t4_cov", cov, 4'b0111);
    chk("t4_not_done", done, 0);
    smp(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4_done", done, 1);
    chk("t4_vec5", vec_cnt, 5);
    chk("t4_pass", pass, 1);
    chk("t4_and_pass", pass_and, 1);
    chk("t4_and_vec", vec_and, 5);

    // 5: restart with coincident sample, then saturation
    do_start();
    smp(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_vec1", vec_cnt, 1);
    start = 1'b1;
    smp(1'b1, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    chk("t5_drop_vec", vec_cnt, 0);
    chk("t5_drop_err", err_cnt, 0);
    chk("t5_drop_cov", cov, 0);
    chk("t5_drop_mm", mismatch, 0);
    chk("t5_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) smp(1'b0, 1'b0, 1'b0, 1'b1);
      else            smp(1'b0, 1'b1, 1'b1, 1'b1);
      chk("t5_mm_run", mismatch, 1);
    end
    chk("t5_err", err_cnt, 5);
    chk("t5_sat_err", err_sat, 3);
    chk("t5_sat_vec", vec_sat, 3);
    chk("t5_and_err", err_and, 5);
    chk("t5_not_done", done, 0);
    smp(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_mm_clear", mismatch, 0);
    smp(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_done", done, 1);
    chk("t5_vec", vec_cnt, 7);
    chk("t5_sat_err_hold", err_sat, 3);
    chk("t5_sat_pass", pass_sat, 0);
    chk("t5_pass", pass, 0);

`ifdef GATE_CHK_TIMEOUT_EN
    // 6: timeout with partial coverage
    do_start();
    chk("t6_tmo_clr0", timeout, 0);
    smp(1'b0, 1'b0, 1'b1, 1'b0);
    smp(1'b0, 1'b1, 1'b0, 1'b0);
    cycles = 2;
    while (!done && cycles < 40) begin
      tick();
      cycles++;
    end
    chk("t6_cycles", cycles, 10);
    chk("t6_timeout", timeout, 1);
    chk("t6_done", done, 1);
    chk("t6_pass", pass, 0);
    chk("t6_cov", cov, 4'b0011);
    do_start();
    chk("t6_tmo_clr", timeout, 0);
    chk("t6_busy", busy, 1);
`endif

    // rst has priority mid-CHECK
    do_start();
    smp(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst2_mm_pre", mismatch, 1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rst2_busy", busy, 0);
    chk("rst2_vec", vec_cnt, 0);
    chk("rst2_mm", mismatch, 0);
    chk("rst2_err", err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
